// File: rtl/sync_ram_pkg.sv
// Shared types, constants and the byte-lane merge helper for sync_dualport_ram_be.
package sync_ram_pkg;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  // Widest word / lane count the merge helper handles; callers pad and truncate.
  localparam int unsigned MERGE_MAX_W  = 256;
  localparam int unsigned MERGE_MAX_NB = 256;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  // Take lane i from new_w where be[i] is set, otherwise keep old_w.
  function automatic logic [MERGE_MAX_W-1:0] merge_be(
    input logic [MERGE_MAX_W-1:0]  old_w,
    input logic [MERGE_MAX_W-1:0]  new_w,
    input logic [MERGE_MAX_NB-1:0] be,
    input int unsigned             byte_w
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int unsigned b = 0; b < MERGE_MAX_W; b++) begin
      if (be[8'(b / byte_w)]) res[8'(b)] = new_w[8'(b)];
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_ram_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once with a zero write, then raises ready.
module sync_ram_clear_ctrl
  import sync_ram_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 clr_we,
  output logic [ADDR_SIZE-1:0] clr_addr,
  output logic                 ready
);

  state_t               r_state;
  logic [ADDR_SIZE-1:0] r_cnt;
  logic                 r_we;
  logic                 r_ready;

  // Clear FSM: one word per cycle from 0 to DEPTH-1, then park in READY until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_we    <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_cnt == ADDR_SIZE'(DEPTH - 1)) begin
            r_state <= S_READY;
            r_we    <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_READY: begin
          r_state <= S_READY;
        end
        default: begin
          r_state <= S_CLEAR;
          r_cnt   <= '0;
          r_we    <= 1'b1;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = r_we;
  assign clr_addr = r_cnt;
  assign ready    = r_ready;

endmodule

// File: rtl/sync_dualport_ram_be.sv
// One-clock simple dual-port RAM with byte enables, selectable read-during-write and optional output register.
module sync_dualport_ram_be
  import sync_ram_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_SIZE = $clog2(DEPTH),
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned OUT_REG   = 0,
  parameter int unsigned RDW_MODE  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ADDR_SIZE-1:0]        wr_addr,
  input  logic [(WIDTH/BYTE_W)-1:0]   wr_be,
  input  logic [WIDTH-1:0]            data_in,
  input  logic                        rd_en,
  input  logic [ADDR_SIZE-1:0]        rd_addr,
  output logic [WIDTH-1:0]            data_out,
  output logic                        rd_valid,
  output logic                        collision,
  output logic                        ready
);

  localparam int unsigned NB = WIDTH / BYTE_W;

  logic [WIDTH-1:0]     r_mem [DEPTH];

  logic                 w_clr_we;
  logic [ADDR_SIZE-1:0] w_clr_addr;
  logic                 w_ready;

  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic                 w_wr_ok;
  logic                 w_rd_req;
  logic                 w_coll;
  logic [WIDTH-1:0]     w_wr_word;
  logic [WIDTH-1:0]     w_rd_word;
  logic [WIDTH-1:0]     w_rd_data;

  logic [WIDTH-1:0]     r_s1_data;
  logic                 r_s1_valid;
  logic                 r_s1_coll;

  sync_ram_clear_ctrl #(
    .DEPTH     (DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr),
    .ready    (w_ready)
  );

  assign w_wr_in_range = (32'(wr_addr) < DEPTH);
  assign w_rd_in_range = (32'(rd_addr) < DEPTH);
  assign w_wr_ok       = rst && w_ready && wr_en && w_wr_in_range && (|wr_be);
  assign w_rd_req      = w_ready && rd_en;
  assign w_coll        = w_rd_req && wr_en && w_rd_in_range && (rd_addr == wr_addr);

  assign w_wr_word = WIDTH'(merge_be(MERGE_MAX_W'(r_mem[wr_addr]), MERGE_MAX_W'(data_in),
                                     MERGE_MAX_NB'(wr_be), BYTE_W));
  assign w_rd_word = w_rd_in_range ? r_mem[rd_addr] : '0;

  // New-data bypass merges the in-flight write lanes over the stored word.
  assign w_rd_data = (RDW_MODE == RDW_NEW && w_coll)
                   ? WIDTH'(merge_be(MERGE_MAX_W'(w_rd_word), MERGE_MAX_W'(data_in),
                                     MERGE_MAX_NB'(wr_be), BYTE_W))
                   : w_rd_word;

  // Array write port: clear sequencer owns it until ready, then user byte-enable writes.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= w_wr_word;
    end
  end

  // First read stage: data holds between reads, valid and collision are single-cycle strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_coll  <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_req;
      r_s1_coll  <= w_coll;
      if (w_rd_req) r_s1_data <= w_rd_data;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] r_s2_data;
    logic             r_s2_valid;
    logic             r_s2_coll;

    // Optional second stage adds one cycle of latency to data and both strobes.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_s2_data  <= '0;
        r_s2_valid <= 1'b0;
        r_s2_coll  <= 1'b0;
      end else begin
        r_s2_valid <= r_s1_valid;
        r_s2_coll  <= r_s1_coll;
        if (r_s1_valid) r_s2_data <= r_s1_data;
      end
    end

    assign data_out  = r_s2_data;
    assign rd_valid  = r_s2_valid;
    assign collision = r_s2_coll;
  end else begin : g_no_out_reg
    assign data_out  = r_s1_data;
    assign rd_valid  = r_s1_valid;
    assign collision = r_s1_coll;
  end

  assign ready = w_ready;

  // Keep NB visible as the lane count the byte-enable port is sized by.
  if (NB * BYTE_W != WIDTH) begin : g_bad_width
    $error("WIDTH must be a multiple of BYTE_W");
  end

endmodule

// File: tb/tb_sync_dualport_ram_be.sv
// Directed bench for sync_dualport_ram_be: four configurations share one stimulus stream,
// a reference model pushes expected read results per configuration and they are popped as outputs appear.
module tb_sync_dualport_ram_be;

  localparam int ND = 4;
  // Configurations: 0 new-data, 1 old-data, 2 output register, 3 depth 12.
  localparam int DEP  [ND] = '{16, 16, 16, 12};
  localparam int RDW  [ND] = '{1, 0, 1, 1};
  localparam int OREG [ND] = '{0, 0, 1, 0};

  typedef struct packed {
    logic        v;
    logic        c;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr, wr_be;
  logic [31:0] data_in;

  wire [31:0] dout [ND];
  wire        rv   [ND];
  wire        co   [ND];
  wire        rdy  [ND];

  int n_vec = 0;
  int n_err = 0;

  exp_t        q0[$], q1[$], q2[$], q3[$];
  logic [31:0] mm   [ND][16];
  logic        m_rdy[ND];
  int          m_cnt[ND];
  logic [31:0] last [ND];

  always #5 clk = ~clk;

  sync_dualport_ram_be #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .OUT_REG(0), .RDW_MODE(1)) u_new (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout[0]), .rd_valid(rv[0]), .collision(co[0]),
    .ready(rdy[0]));

  sync_dualport_ram_be #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .OUT_REG(0), .RDW_MODE(0)) u_old (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout[1]), .rd_valid(rv[1]), .collision(co[1]),
    .ready(rdy[1]));

  sync_dualport_ram_be #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .OUT_REG(1), .RDW_MODE(1)) u_oreg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout[2]), .rd_valid(rv[2]), .collision(co[2]),
    .ready(rdy[2]));

  sync_dualport_ram_be #(.WIDTH(32), .DEPTH(12), .BYTE_W(8), .OUT_REG(0), .RDW_MODE(1)) u_d12 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout[3]), .rd_valid(rv[3]), .collision(co[3]),
    .ready(rdy[3]));

  function automatic logic [31:0] mmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, got, exp);
    end
  endtask

  task automatic q_flush(input int d);
    case (d)
      0: q0.delete();
      1: q1.delete();
      2: q2.delete();
      default: q3.delete();
    endcase
  endtask

  task automatic q_push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int d, output exp_t e);
    int sz;
    case (d)
      0: sz = q0.size();
      1: sz = q1.size();
      2: sz = q2.size();
      default: sz = q3.size();
    endcase
    e = '0;
    if (sz == 0) begin
      chk("scoreboard_empty", d, 32'(sz), 32'd1);
    end else begin
      case (d)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        default: e = q3.pop_front();
      endcase
    end
  endtask

  // One clock of stimulus: update the model, clock the DUTs, then compare every configuration.
  task automatic step(input logic r, input logic we, input logic [3:0] wa, input logic [3:0] be,
                      input logic [31:0] di, input logic re, input logic [3:0] ra);
    exp_t e;
    rst = r; wr_en = we; wr_addr = wa; wr_be = be; data_in = di; rd_en = re; rd_addr = ra;
    for (int d = 0; d < ND; d++) begin
      if (!r) begin
        m_rdy[d] = 1'b0;
        m_cnt[d] = 0;
        for (int a = 0; a < 16; a++) mm[d][a] = '0;
        q_flush(d);
        if (OREG[d] != 0) q_push(d, '0);
        last[d] = '0;
      end else begin
        e = '0;
        if (m_rdy[d] && re) begin
          e.v = 1'b1;
          if (int'(ra) < DEP[d]) begin
            e.d = mm[d][ra];
            if (we && wa == ra) begin
              e.c = 1'b1;
              if (RDW[d] != 0) e.d = mmerge(e.d, di, be);
            end
          end
        end
        q_push(d, e);
        if (m_rdy[d] && we && int'(wa) < DEP[d]) mm[d][wa] = mmerge(mm[d][wa], di, be);
        if (!m_rdy[d]) begin
          m_cnt[d]++;
          if (m_cnt[d] == DEP[d]) m_rdy[d] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      if (!r) begin
        chk("rst_valid", d, 32'(rv[d]), 32'd0);
        chk("rst_coll", d, 32'(co[d]), 32'd0);
        chk("rst_data", d, dout[d], 32'd0);
        chk("rst_ready", d, 32'(rdy[d]), 32'd0);
      end else begin
        q_pop(d, e);
        if (e.v) last[d] = e.d;
        chk("rd_valid", d, 32'(rv[d]), 32'(e.v));
        chk("collision", d, 32'(co[d]), 32'(e.c));
        chk("data_out", d, dout[d], last[d]);
        chk("ready", d, 32'(rdy[d]), 32'(m_rdy[d]));
      end
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    step(1'b1, 1'b1, a, be, d, 1'b0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b1, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, a);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; data_in = '0;

    // Reset, then clear: ready rises after DEPTH cycles and every word reads back zero.
    step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd0);
    for (int i = 0; i < 15; i++) idle();
    chk("ready_at_15", 0, 32'(rdy[0]), 32'd0);
    idle();
    chk("ready_at_16", 0, 32'(rdy[0]), 32'd1);
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle();
    idle();

    // Byte-enable partial overwrite.
    wr(4'd5, 4'b1111, 32'hAABBCCDD);
    wr(4'd5, 4'b0101, 32'h11223344);
    rd(4'd5);
    chk("be_merge_data", 0, dout[0], 32'hAA22CC44);
    chk("be_merge_valid", 0, 32'(rv[0]), 32'd1);
    chk("be_merge_coll", 0, 32'(co[0]), 32'd0);
    idle();

    // Same-address read during write in both RDW modes.
    wr(4'd3, 4'b1111, 32'h01020304);
    step(1'b1, 1'b1, 4'd3, 4'b0011, 32'hFFFFFFFF, 1'b1, 4'd3);
    chk("rdw_new_data", 0, dout[0], 32'h0102FFFF);
    chk("rdw_new_coll", 0, 32'(co[0]), 32'd1);
    chk("rdw_old_data", 1, dout[1], 32'h01020304);
    chk("rdw_old_coll", 1, 32'(co[1]), 32'd1);
    rd(4'd3);
    chk("rdw_after_new", 0, dout[0], 32'h0102FFFF);
    chk("rdw_after_old", 1, dout[1], 32'h0102FFFF);
    chk("rdw_after_coll", 1, 32'(co[1]), 32'd0);
    idle();

    // Output-register latency with back-to-back reads.
    wr(4'd1, 4'b1111, 32'h11111111);
    wr(4'd2, 4'b1111, 32'h22222222);
    rd(4'd1);
    chk("oreg_lat_not_yet", 2, 32'(rv[2]), 32'd0);
    rd(4'd2);
    chk("oreg_first", 2, dout[2], 32'h11111111);
    rd(4'd3);
    chk("oreg_second", 2, dout[2], 32'h22222222);
    idle();
    chk("oreg_third", 2, dout[2], 32'h0102FFFF);
    chk("oreg_third_valid", 2, 32'(rv[2]), 32'd1);
    idle();
    chk("oreg_drained", 2, 32'(rv[2]), 32'd0);

    // Reset with reads in flight, then re-clear.
    wr(4'd7, 4'b1111, 32'h77777777);
    rd(4'd7);
    rd(4'd7);
    step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd7);
    chk("midrst_oreg_valid", 2, 32'(rv[2]), 32'd0);
    for (int i = 0; i < 16; i++) idle();
    rd(4'd7);
    chk("recleared_7", 0, dout[0], 32'd0);
    chk("recleared_7_valid", 0, 32'(rv[0]), 32'd1);
    rd(4'd5);
    idle();
    idle();

    // Out-of-range accesses on the 12-word instance.
    wr(4'd13, 4'b1111, 32'h5A5A5A5A);
    rd(4'd13);
    chk("oor_data", 3, dout[3], 32'd0);
    chk("oor_valid", 3, 32'(rv[3]), 32'd1);
    chk("inrange_13", 0, dout[0], 32'h5A5A5A5A);
    for (int a = 0; a < 12; a++) rd(4'(a));
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
